divider_bank: RTL
=================

# divider_bank

Parametrised multi-channel clock divider and tick generator. It is the successor to the single fixed-ratio toggle divider. Each channel has a run-time programmable divisor, per-channel enable, a one-cycle tick output and a 50 % square output. All channels can be restarted in phase with a common sync strobe. The block sits beside the system clock input and feeds slow enables (game step, display refresh, debounce sampling) to the rest of the design.

## Interface
- `CH`, 2: number of independent channels (1..8).
- `W`, 27: divisor/counter width in bits.
- `DEFAULT_DIV`, 50000000: divisor loaded into every channel at reset; must fit in `W` bits.
- `I_CLK` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in `CH`: per-channel run enable.
- `sync` in 1: one-cycle strobe that restarts all channels in phase.
- `div_we` in 1: divisor write strobe.
- `div_sel` in max(1, clog2(`CH`)): channel index for the write.
- `div_data` in `W`: divisor value to write.
- `O_CLK` out `CH`: per-channel square output, period 2·div cycles.
- `O_TICK` out `CH`: per-channel one-cycle pulse, period div cycles.
- `pend` out `CH`: shadow-divisor-pending flag. Present only with `DIVIDER_PEND_FLAG_EN`.

## Operation
- Per-channel state:
  - `cnt` (W bits), counter.
  - `div_act`, active divisor.
  - `div_shd`, shadow divisor.
  - `pnd`, pending bit.
  - Output registers `O_CLK[i]` and `O_TICK[i]`.
- Reset state:
  - `cnt` = 0.
  - `div_act` = `div_shd` = `DEFAULT_DIV`.
  - `pnd` = 0.
  - `O_CLK` = 0, `O_TICK` = 0, `pend` = 0.
- Running (`en[i]`=1, `div_act`≠0):
  - `cnt` increments each cycle.
  - When `cnt` == `div_act`−1 (terminal count, TC), `cnt` returns to 0, `O_CLK[i]` toggles and `O_TICK[i]` is set for exactly one cycle.
  - At all other times `O_TICK[i]`=0.
- `div_act`=1: `O_TICK[i]` stays high continuously and `O_CLK[i]` toggles every cycle.
- `div_act`=0: the channel is halted. `cnt` holds, `O_CLK[i]` holds, `O_TICK[i]`=0.
- `en[i]`=0: `cnt` and `O_CLK[i]` hold and `O_TICK[i]`=0. Counting resumes from the held `cnt` when `en[i]` returns high.
- Divisor write (`div_we`=1, `div_sel`<`CH`):
  - `div_data` goes to `div_shd[sel]`.
  - If the channel is running, `pnd` is set and `div_shd` moves to `div_act` at the next TC, in the same edge that resets `cnt`. This keeps output phases glitch-free.
  - If the channel is disabled or halted, `div_act` loads directly, `cnt` clears and `pnd` stays 0.
- `div_sel` ≥ `CH`: the write is ignored.
- A second write while `pnd`=1 overwrites `div_shd`. Only the last value is applied.
- Write on the same edge as TC of that channel: the TC transfers the old shadow. The new value stays pending until the following TC.
- `sync`=1 acts on all channels, regardless of `en`:
  - `cnt` ← 0.
  - `O_CLK` ← 0.
  - `O_TICK` ← 0.
  - `div_act` ← `div_shd`.
  - `pnd` ← 0.
- `sync` and `div_we` on the same edge: `div_data` goes straight to `div_act[sel]` and `div_shd[sel]`, and `pnd`=0.
- Widths: TC compare is done in `W` bits and no counter overflow is possible. A divisor of 2^W−1 is legal.

## Timing
- `O_CLK` and `O_TICK` are registered. They change on the edge where TC is detected, so they are visible one cycle after `cnt` reads `div_act`−1.
- From reset release or `sync`, with divisor D, the first tick is high during cycle D (cycles counted from 1 after release). Ticks then recur every D cycles.
- Pending divisor: the new period starts with the cycle after the TC edge that transfers it.
- `rst` asserts asynchronously mid-count and forces all reset values immediately. Release is synchronous to the next `I_CLK` edge.

## Configuration
- `DIVIDER_PEND_FLAG_EN` defined: the `pend` output port exists and mirrors `pnd` per channel, registered, with the same timing as `pnd`.
- Not defined: the port is absent. Internal shadow behaviour is identical.

## Test plan
- Reset, `CH`=2, `DEFAULT_DIV`=4, `en`=11 → `O_TICK` pulses on cycles 4, 8, 12 and `O_CLK` period is 8 cycles on both channels.
- Channel 0 running at div 4, write div 6 at cycle 2 → `pend[0]`=1 until the cycle-4 TC. The next ticks are at cycles 10 and 16.
- Write div 1 to a disabled channel 1, then enable it → `O_TICK[1]` is high continuously and `O_CLK[1]` toggles every cycle.
- Write div 0 to a running channel → after its next TC the outputs freeze and `O_TICK`=0. Write 3 → the channel restarts and ticks 3 cycles later.
- Channels at div 3 and div 5 out of phase, pulse `sync` → both `O_CLK`=0, and the first ticks land 3 and 5 cycles after `sync`.
- Assert `rst` asynchronously mid-count → all outputs are 0 immediately. After release, ticks follow `DEFAULT_DIV` with no residual pending write.

Source files
------------

// File: rtl/divider_bank_if.sv
// Control/status bundle for divider_bank: run enables, sync strobe, divisor write port and outputs.
// The pend signal exists only when DIVIDER_PEND_FLAG_EN is defined.
interface divider_bank_if #(
  parameter int CH = 2,
  parameter int W  = 27
);
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] en;
  logic          sync;
  logic          div_we;
  logic [SW-1:0] div_sel;
  logic [W-1:0]  div_data;
  logic [CH-1:0] O_CLK;
  logic [CH-1:0] O_TICK;
`ifdef DIVIDER_PEND_FLAG_EN
  logic [CH-1:0] pend;

  modport master (output en, sync, div_we, div_sel, div_data,
                  input  O_CLK, O_TICK, pend);
  modport slave  (input  en, sync, div_we, div_sel, div_data,
                  output O_CLK, O_TICK, pend);
`else
  modport master (output en, sync, div_we, div_sel, div_data,
                  input  O_CLK, O_TICK);
  modport slave  (input  en, sync, div_we, div_sel, div_data,
                  output O_CLK, O_TICK);
`endif
endinterface

// File: rtl/divider_bank.sv
// Multi-channel programmable clock divider / tick generator with shadowed divisors and common sync.
// Optional pend output enabled by DIVIDER_PEND_FLAG_EN.
module divider_bank #(
  parameter int              CH          = 2,
  parameter int              W           = 27,
  parameter longint unsigned DEFAULT_DIV = 50000000
) (
  input logic           I_CLK,
  input logic           rst,
  divider_bank_if.slave bus
);
  localparam int         SW  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

  logic [W-1:0]  cnt     [CH];
  logic [W-1:0]  div_act [CH];
  logic [W-1:0]  div_shd [CH];
  logic [CH-1:0] pnd;
  logic [CH-1:0] o_clk;
  logic [CH-1:0] o_tick;

  logic [CH-1:0] wr;
  logic [CH-1:0] run;
  logic [CH-1:0] tc;

  always_comb begin
    wr  = '0;
    run = '0;
    tc  = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      wr[i]  = bus.div_we && (bus.div_sel == SW'(i));
      run[i] = bus.en[i] && (div_act[i] != '0);
      tc[i]  = run[i] && (cnt[i] == div_act[i] - W'(1));
    end
  end

  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= DEF;
        div_shd[i] <= DEF;
      end
      pnd    <= '0;
      o_clk  <= '0;
      o_tick <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (bus.sync) begin
          cnt[i]    <= '0;
          o_clk[i]  <= 1'b0;
          o_tick[i] <= 1'b0;
          pnd[i]    <= 1'b0;
          if (wr[i]) begin
            div_act[i] <= bus.div_data;
            div_shd[i] <= bus.div_data;
          end else begin
            div_act[i] <= div_shd[i];
          end
        end else if (run[i]) begin
          o_tick[i] <= tc[i];
          if (tc[i]) begin
            cnt[i]   <= '0;
            o_clk[i] <= ~o_clk[i];
            if (pnd[i]) div_act[i] <= div_shd[i];
          end else begin
            cnt[i] <= cnt[i] + W'(1);
          end
          // A write coinciding with TC stays pending: the TC consumes the old shadow.
          if (wr[i]) begin
            div_shd[i] <= bus.div_data;
            pnd[i]     <= 1'b1;
          end else if (tc[i]) begin
            pnd[i] <= 1'b0;
          end
        end else begin
          o_tick[i] <= 1'b0;
          if (wr[i]) begin
            div_act[i] <= bus.div_data;
            div_shd[i] <= bus.div_data;
            cnt[i]     <= '0;
            pnd[i]     <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.O_CLK  = o_clk;
  assign bus.O_TICK = o_tick;
`ifdef DIVIDER_PEND_FLAG_EN
  assign bus.pend   = pnd;
`endif
endmodule
